rca_config_loader: RTL and testbench

Sequencer that programs one RCA's configuration into the RCA configuration register file from a stream of 32-bit config records (CPU/DMA). It locks the target RCA against new issue and waits for in-flight ops to drain. It then converts each accepted record into exactly one single-cycle write strobe on the config-reg write interfaces, and pulses done when finished. This is the sole writer of the config regs.

---
 rtl/rca_config_pkg.sv | 37 +++
 rtl/rca_cfg_record_decoder.sv | 116 +++++++++++
 rtl/rca_config_loader.sv | 208 ++++++++++++++++++++
 tb/tb_rca_config_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_config_pkg
// Purpose  : Shared types for the RCA configuration loader: config record
//            type codes, record field positions and loader FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rca_config_pkg;

    // Record type codes carried in bits [31:28]; codes 7..15 are illegal.
    typedef enum logic [3:0] {
        REC_CPU_SRC      = 4'd0,
        REC_CPU_DEST_FB  = 4'd1,
        REC_CPU_DEST_NFB = 4'd2,
        REC_GRID         = 4'd3,
        REC_IO           = 4'd4,
        REC_RESULT       = 4'd5,
        REC_IO_INP_MAP   = 4'd6
    } cfg_rec_type_t;

    localparam int REC_TYPE_MSB = 31;
    localparam int REC_TYPE_LSB = 28;
    localparam int REC_ADDR_MSB = 27;
    localparam int REC_ADDR_LSB = 16;
    localparam int REC_DATA_MSB = 15;
    localparam int REC_DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/rca_cfg_record_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rca_cfg_record_decoder
// Purpose  : Combinational decode of one 32-bit config record into a single
//            write strobe plus its address/data fields, or an illegal flag.
// Ports    : record            - raw config record
//            *_wr_en           - at most one asserted for a legal record
//            port/addr/sel/map - fields truncated to destination widths
//            illegal           - record type is not a known code
// Revision : 1.0 - initial release
// ============================================================================
module rca_cfg_record_decoder
    import rca_config_pkg::*;
#(
    parameter int PORT_W      = 2,
    parameter int GRID_ADDR_W = 6,
    parameter int GRID_SEL_W  = 4,
    parameter int IO_ADDR_W   = 2,
    parameter int IO_SEL_W    = 3,
    parameter int RES_ADDR_W  = 2,
    parameter int RES_SEL_W   = 2,
    parameter int MAP_W       = 4
) (
    input  logic [31:0]            record,
    output logic                   fb_wr_en,
    output logic                   nfb_wr_en,
    output logic                   grid_wr_en,
    output logic                   io_wr_en,
    output logic                   res_wr_en,
    output logic                   map_wr_en,
    output logic [PORT_W-1:0]      port_sel,
    output logic                   src_dest,
    output logic [4:0]             reg_addr,
    output logic [GRID_ADDR_W-1:0] grid_addr,
    output logic [GRID_SEL_W-1:0]  grid_sel,
    output logic [IO_ADDR_W-1:0]   io_addr,
    output logic [IO_SEL_W-1:0]    io_sel,
    output logic [RES_ADDR_W-1:0]  res_addr,
    output logic [RES_SEL_W-1:0]   res_sel,
    output logic [MAP_W-1:0]       inp_map,
    output logic                   illegal
);

    logic [3:0]  w_type;
    logic [11:0] w_addr;
    logic [15:0] w_data;
    logic        w_unused;

    assign w_type = record[REC_TYPE_MSB:REC_TYPE_LSB];
    assign w_addr = record[REC_ADDR_MSB:REC_ADDR_LSB];
    assign w_data = record[REC_DATA_MSB:REC_DATA_LSB];

    // Upper field bits beyond each destination width are intentionally dropped.
    assign w_unused = ^{w_addr, w_data};

    always_comb begin
        fb_wr_en   = 1'b0;
        nfb_wr_en  = 1'b0;
        grid_wr_en = 1'b0;
        io_wr_en   = 1'b0;
        res_wr_en  = 1'b0;
        map_wr_en  = 1'b0;
        port_sel   = '0;
        src_dest   = 1'b0;
        reg_addr   = '0;
        grid_addr  = '0;
        grid_sel   = '0;
        io_addr    = '0;
        io_sel     = '0;
        res_addr   = '0;
        res_sel    = '0;
        inp_map    = '0;
        illegal    = 1'b0;
        case (cfg_rec_type_t'(w_type))
            REC_CPU_SRC: begin
                fb_wr_en = 1'b1;
                port_sel = w_addr[PORT_W-1:0];
                reg_addr = w_data[4:0];
            end
            REC_CPU_DEST_FB: begin
                fb_wr_en = 1'b1;
                port_sel = w_addr[PORT_W-1:0];
                src_dest = 1'b1;
                reg_addr = w_data[4:0];
            end
            REC_CPU_DEST_NFB: begin
                nfb_wr_en = 1'b1;
                port_sel  = w_addr[PORT_W-1:0];
                src_dest  = 1'b1;
                reg_addr  = w_data[4:0];
            end
            REC_GRID: begin
                grid_wr_en = 1'b1;
                grid_addr  = w_addr[GRID_ADDR_W-1:0];
                grid_sel   = w_data[GRID_SEL_W-1:0];
            end
            REC_IO: begin
                io_wr_en = 1'b1;
                io_addr  = w_addr[IO_ADDR_W-1:0];
                io_sel   = w_data[IO_SEL_W-1:0];
            end
            REC_RESULT: begin
                res_wr_en = 1'b1;
                res_addr  = w_addr[RES_ADDR_W-1:0];
                res_sel   = w_data[RES_SEL_W-1:0];
            end
            REC_IO_INP_MAP: begin
                map_wr_en = 1'b1;
                inp_map   = w_data[MAP_W-1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rca_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : rca_config_loader
// Purpose  : Sole writer of the RCA config register file. Locks the target
//            RCA, waits for its in-flight ops to drain, then turns each
//            accepted 32-bit record into one registered write strobe and
//            pulses done at the end.
// Ports    : start/start_ready/start_rca/start_num_words - load request
//            abort                  - cancel load in DRAIN or LOAD
//            cfg_valid/cfg_data/cfg_ready - record stream
//            rca_in_flight/rca_lock/rca_sel - issue-logic interlock
//            *_wr_en + field outputs - config register write interfaces
//            done/err_illegal/aborted - status
// Revision : 1.0 - initial release
// ============================================================================
module rca_config_loader
    import rca_config_pkg::*;
#(
    parameter int NUM_RCAS           = 4,
    parameter int NUM_READ_PORTS     = 4,
    parameter int NUM_WRITE_PORTS    = 4,
    parameter int GRID_NUM_ROWS      = 4,
    parameter int NUM_GRID_MUXES     = 64,
    parameter int GRID_MUX_INPUTS    = 16,
    parameter int IO_UNIT_MUX_INPUTS = 8,
    parameter int MAX_WORDS          = 256,
    localparam int RCA_W       = $clog2(NUM_RCAS),
    localparam int CNT_W       = $clog2(MAX_WORDS + 1),
    localparam int PORT_W      = $clog2(NUM_READ_PORTS),
    localparam int GRID_ADDR_W = $clog2(NUM_GRID_MUXES),
    localparam int GRID_SEL_W  = $clog2(GRID_MUX_INPUTS),
    localparam int IO_ADDR_W   = $clog2(GRID_NUM_ROWS),
    localparam int IO_SEL_W    = $clog2(IO_UNIT_MUX_INPUTS),
    localparam int RES_ADDR_W  = $clog2(NUM_WRITE_PORTS),
    localparam int RES_SEL_W   = $clog2(GRID_NUM_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   start_ready,
    input  logic [RCA_W-1:0]       start_rca,
    input  logic [CNT_W-1:0]       start_num_words,
    input  logic                   abort,
    input  logic                   cfg_valid,
    input  logic [31:0]            cfg_data,
    output logic                   cfg_ready,
    input  logic [NUM_RCAS-1:0]    rca_in_flight,
    output logic [NUM_RCAS-1:0]    rca_lock,
    output logic [RCA_W-1:0]       rca_sel,
    output logic                   cpu_fb_reg_addr_wr_en,
    output logic                   cpu_nfb_reg_addr_wr_en,
    output logic                   grid_mux_wr_en,
    output logic                   io_mux_wr_en,
    output logic                   rca_result_mux_wr_en,
    output logic                   rca_io_inp_map_wr_en,
    output logic [PORT_W-1:0]      cpu_port_sel,
    output logic                   cpu_src_dest_port,
    output logic [4:0]             cpu_reg_addr,
    output logic [GRID_ADDR_W-1:0] grid_mux_addr,
    output logic [GRID_SEL_W-1:0]  new_grid_mux_sel,
    output logic [IO_ADDR_W-1:0]   io_mux_addr,
    output logic [IO_SEL_W-1:0]    new_io_mux_sel,
    output logic [RES_ADDR_W-1:0]  rca_result_mux_addr,
    output logic [RES_SEL_W-1:0]   new_rca_result_mux_sel,
    output logic [GRID_NUM_ROWS-1:0] new_rca_io_inp_map,
    output logic                   done,
    output logic                   err_illegal,
    output logic                   aborted
);

    loader_state_t r_state;
    loader_state_t w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic w_start_acc, w_hs, w_last, w_abort_act;

    logic w_dec_fb, w_dec_nfb, w_dec_grid, w_dec_io, w_dec_res, w_dec_map;
    logic w_dec_sd, w_dec_illegal;
    logic [PORT_W-1:0]        w_dec_port;
    logic [4:0]               w_dec_reg;
    logic [GRID_ADDR_W-1:0]   w_dec_gaddr;
    logic [GRID_SEL_W-1:0]    w_dec_gsel;
    logic [IO_ADDR_W-1:0]     w_dec_ioaddr;
    logic [IO_SEL_W-1:0]      w_dec_iosel;
    logic [RES_ADDR_W-1:0]    w_dec_raddr;
    logic [RES_SEL_W-1:0]     w_dec_rsel;
    logic [GRID_NUM_ROWS-1:0] w_dec_map_val;

    rca_cfg_record_decoder #(
        .PORT_W      (PORT_W),
        .GRID_ADDR_W (GRID_ADDR_W),
        .GRID_SEL_W  (GRID_SEL_W),
        .IO_ADDR_W   (IO_ADDR_W),
        .IO_SEL_W    (IO_SEL_W),
        .RES_ADDR_W  (RES_ADDR_W),
        .RES_SEL_W   (RES_SEL_W),
        .MAP_W       (GRID_NUM_ROWS)
    ) u_decoder (
        .record     (cfg_data),
        .fb_wr_en   (w_dec_fb),
        .nfb_wr_en  (w_dec_nfb),
        .grid_wr_en (w_dec_grid),
        .io_wr_en   (w_dec_io),
        .res_wr_en  (w_dec_res),
        .map_wr_en  (w_dec_map),
        .port_sel   (w_dec_port),
        .src_dest   (w_dec_sd),
        .reg_addr   (w_dec_reg),
        .grid_addr  (w_dec_gaddr),
        .grid_sel   (w_dec_gsel),
        .io_addr    (w_dec_ioaddr),
        .io_sel     (w_dec_iosel),
        .res_addr   (w_dec_raddr),
        .res_sel    (w_dec_rsel),
        .inp_map    (w_dec_map_val),
        .illegal    (w_dec_illegal)
    );

    assign start_ready = (r_state == ST_IDLE);
    assign cfg_ready   = (r_state == ST_LOAD) && (r_remaining != '0);
    assign done        = (r_state == ST_DONE);
    // Lock is held from DRAIN through DONE so issue cannot race the writes.
    assign rca_lock    = (r_state != ST_IDLE) ? (NUM_RCAS'(1) << rca_sel) : '0;

    assign w_start_acc = start && start_ready;
    assign w_hs        = cfg_valid && cfg_ready;
    assign w_last      = w_hs && (r_remaining == CNT_W'(1));
    assign w_abort_act = abort && ((r_state == ST_DRAIN) || (r_state == ST_LOAD));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!rca_in_flight[rca_sel]) begin
                    w_state_nxt = (r_remaining == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                <= ST_IDLE;
            r_remaining            <= '0;
            rca_sel                <= '0;
            err_illegal            <= 1'b0;
            aborted                <= 1'b0;
            cpu_fb_reg_addr_wr_en  <= 1'b0;
            cpu_nfb_reg_addr_wr_en <= 1'b0;
            grid_mux_wr_en         <= 1'b0;
            io_mux_wr_en           <= 1'b0;
            rca_result_mux_wr_en   <= 1'b0;
            rca_io_inp_map_wr_en   <= 1'b0;
            cpu_port_sel           <= '0;
            cpu_src_dest_port      <= 1'b0;
            cpu_reg_addr           <= '0;
            grid_mux_addr          <= '0;
            new_grid_mux_sel       <= '0;
            io_mux_addr            <= '0;
            new_io_mux_sel         <= '0;
            rca_result_mux_addr    <= '0;
            new_rca_result_mux_sel <= '0;
            new_rca_io_inp_map     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                rca_sel     <= start_rca;
                r_remaining <= start_num_words;
                err_illegal <= 1'b0;
                aborted     <= 1'b0;
            end else begin
                if (w_hs)                 r_remaining <= r_remaining - CNT_W'(1);
                if (w_hs && w_dec_illegal) err_illegal <= 1'b1;
                if (w_abort_act)          aborted     <= 1'b1;
            end
            // Strobes and fields live for exactly the cycle after a handshake;
            // a record accepted alongside abort still gets written.
            cpu_fb_reg_addr_wr_en  <= w_hs && w_dec_fb;
            cpu_nfb_reg_addr_wr_en <= w_hs && w_dec_nfb;
            grid_mux_wr_en         <= w_hs && w_dec_grid;
            io_mux_wr_en           <= w_hs && w_dec_io;
            rca_result_mux_wr_en   <= w_hs && w_dec_res;
            rca_io_inp_map_wr_en   <= w_hs && w_dec_map;
            cpu_port_sel           <= w_hs ? w_dec_port    : '0;
            cpu_src_dest_port      <= w_hs && w_dec_sd;
            cpu_reg_addr           <= w_hs ? w_dec_reg     : '0;
            grid_mux_addr          <= w_hs ? w_dec_gaddr   : '0;
            new_grid_mux_sel       <= w_hs ? w_dec_gsel    : '0;
            io_mux_addr            <= w_hs ? w_dec_ioaddr  : '0;
            new_io_mux_sel         <= w_hs ? w_dec_iosel   : '0;
            rca_result_mux_addr    <= w_hs ? w_dec_raddr   : '0;
            new_rca_result_mux_sel <= w_hs ? w_dec_rsel    : '0;
            new_rca_io_inp_map     <= w_hs ? w_dec_map_val : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rca_config_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rca_config_loader
// Purpose  : Self-checking bench for rca_config_loader: record table with
//            expected write bundles, strobe scoreboard, and directed
//            sequences for drain, illegal record, abort, zero-length load
//            and mid-load reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_ready, abort, cfg_valid, cfg_ready;
    logic [1:0]  start_rca;
    logic [8:0]  start_num_words;
    logic [31:0] cfg_data;
    logic [3:0]  rca_in_flight, rca_lock;
    logic [1:0]  rca_sel;
    logic        fb_we, nfb_we, grid_we, io_we, res_we, map_we;
    logic [1:0]  cpu_port_sel;
    logic        cpu_src_dest_port;
    logic [4:0]  cpu_reg_addr;
    logic [5:0]  grid_mux_addr;
    logic [3:0]  new_grid_mux_sel;
    logic [1:0]  io_mux_addr;
    logic [2:0]  new_io_mux_sel;
    logic [1:0]  rca_result_mux_addr;
    logic [1:0]  new_rca_result_mux_sel;
    logic [3:0]  new_rca_io_inp_map;
    logic        done, err_illegal, aborted;

    always #5 clk = ~clk;

    rca_config_loader dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .start_ready            (start_ready),
        .start_rca              (start_rca),
        .start_num_words        (start_num_words),
        .abort                  (abort),
        .cfg_valid              (cfg_valid),
        .cfg_data               (cfg_data),
        .cfg_ready              (cfg_ready),
        .rca_in_flight          (rca_in_flight),
        .rca_lock               (rca_lock),
        .rca_sel                (rca_sel),
        .cpu_fb_reg_addr_wr_en  (fb_we),
        .cpu_nfb_reg_addr_wr_en (nfb_we),
        .grid_mux_wr_en         (grid_we),
        .io_mux_wr_en           (io_we),
        .rca_result_mux_wr_en   (res_we),
        .rca_io_inp_map_wr_en   (map_we),
        .cpu_port_sel           (cpu_port_sel),
        .cpu_src_dest_port      (cpu_src_dest_port),
        .cpu_reg_addr           (cpu_reg_addr),
        .grid_mux_addr          (grid_mux_addr),
        .new_grid_mux_sel       (new_grid_mux_sel),
        .io_mux_addr            (io_mux_addr),
        .new_io_mux_sel         (new_io_mux_sel),
        .rca_result_mux_addr    (rca_result_mux_addr),
        .new_rca_result_mux_sel (new_rca_result_mux_sel),
        .new_rca_io_inp_map     (new_rca_io_inp_map),
        .done                   (done),
        .err_illegal            (err_illegal),
        .aborted                (aborted)
    );

    // we[5:0] = {fb, nfb, grid, io, result, io_inp_map}
    typedef struct packed {
        logic [5:0] we;
        logic [1:0] port;
        logic       sd;
        logic [4:0] regno;
        logic [5:0] gaddr;
        logic [3:0] gsel;
        logic [1:0] ioaddr;
        logic [2:0] iosel;
        logic [1:0] raddr;
        logic [1:0] rsel;
        logic [3:0] imap;
    } bundle_t;

    typedef struct {
        logic [31:0] rec;
        logic        legal;
        bundle_t     exp;
    } vec_t;

    bundle_t act;
    assign act = {fb_we, nfb_we, grid_we, io_we, res_we, map_we, cpu_port_sel,
                  cpu_src_dest_port, cpu_reg_addr, grid_mux_addr, new_grid_mux_sel,
                  io_mux_addr, new_io_mux_sel, rca_result_mux_addr,
                  new_rca_result_mux_sel, new_rca_io_inp_map};

    vec_t    vec [9];
    bundle_t sb_q[$];
    int      checks = 0;
    int      errors = 0;

    function automatic bundle_t mk(input logic [5:0] we, input logic [1:0] port,
                                   input logic sd, input logic [4:0] rg,
                                   input logic [5:0] ga, input logic [3:0] gs,
                                   input logic [1:0] ia, input logic [2:0] isel,
                                   input logic [1:0] ra, input logic [1:0] rs,
                                   input logic [3:0] m);
        return {we, port, sd, rg, ga, gs, ia, isel, ra, rs, m};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe scoreboard: every strobe must be one-hot and match the next
    // expected bundle in order.
    always @(negedge clk) begin
        if (!$isunknown(act.we) && act.we != 6'b0) begin
            check("strobe_onehot", 64'($countones(act.we)), 64'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got 0x%0h want none at %0t", act, $time);
            end else begin
                check("strobe_fields", act, sb_q.pop_front());
            end
        end
    end

    task automatic run_load(input int rca, input int first, input int cnt, input logic exp_err);
        check("start_ready", start_ready, 1);
        start = 1'b1; start_rca = 2'(rca); start_num_words = 9'(cnt);
        tick();
        start = 1'b0;
        check("drain_lock", rca_lock, 4'b1 << rca);
        check("drain_cfg_ready", cfg_ready, 0);
        check("rca_sel", rca_sel, rca);
        tick();
        check("load_cfg_ready", cfg_ready, 1);
        for (int i = 0; i < cnt; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = vec[first+i].rec;
            if (vec[first+i].legal) sb_q.push_back(vec[first+i].exp);
            tick();
        end
        cfg_valid = 1'b0;
        check("done_pulse", done, 1);
        check("done_with_strobe", act.we != 6'b0, vec[first+cnt-1].legal);
        check("done_lock", rca_lock, 4'b1 << rca);
        tick();
        check("done_low", done, 0);
        check("lock_released", rca_lock, 0);
        check("err_illegal", err_illegal, exp_err);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        vec[0] = '{32'h0001_0007, 1'b1, mk(6'b100000, 2'd1, 1'b0, 5'd7,  6'd0,  4'd0,  2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};
        vec[1] = '{32'h3005_000B, 1'b1, mk(6'b001000, 2'd0, 1'b0, 5'd0,  6'd5,  4'd11, 2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};
        vec[2] = '{32'h6000_0005, 1'b1, mk(6'b000001, 2'd0, 1'b0, 5'd0,  6'd0,  4'd0,  2'd0, 3'd0, 2'd0, 2'd0, 4'b0101)};
        vec[3] = '{32'h9000_0000, 1'b0, mk(6'b000000, 2'd0, 1'b0, 5'd0,  6'd0,  4'd0,  2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};
        vec[4] = '{32'h1002_001F, 1'b1, mk(6'b100000, 2'd2, 1'b1, 5'd31, 6'd0,  4'd0,  2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};
        vec[5] = '{32'h2003_0024, 1'b1, mk(6'b010000, 2'd3, 1'b1, 5'd4,  6'd0,  4'd0,  2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};
        vec[6] = '{32'h4003_0006, 1'b1, mk(6'b000100, 2'd0, 1'b0, 5'd0,  6'd0,  4'd0,  2'd3, 3'd6, 2'd0, 2'd0, 4'h0)};
        vec[7] = '{32'h5001_0003, 1'b1, mk(6'b000010, 2'd0, 1'b0, 5'd0,  6'd0,  4'd0,  2'd0, 3'd0, 2'd1, 2'd3, 4'h0)};
        vec[8] = '{32'h303F_00FF, 1'b1, mk(6'b001000, 2'd0, 1'b0, 5'd0,  6'd63, 4'd15, 2'd0, 3'd0, 2'd0, 2'd0, 4'h0)};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        start_rca = '0; start_num_words = '0; rca_in_flight = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_start_ready", start_ready, 1);
        check("rst_lock", rca_lock, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err_illegal, 0);
        check("rst_aborted", aborted, 0);
        check("rst_outputs", act, 0);
        tick();

        // Basic 3-record load on RCA 2
        run_load(2, 0, 3, 1'b0);

        // Drain: RCA 1 busy for 10 cycles
        rca_in_flight = 4'b0010;
        start = 1'b1; start_rca = 2'd1; start_num_words = 9'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("drain_hold_ready", cfg_ready, 0);
            check("drain_hold_lock", rca_lock, 4'b0010);
            if (i < 9) tick();
        end
        rca_in_flight = 4'b0000;
        tick();
        check("drain_exit_ready", cfg_ready, 1);
        for (int i = 5; i < 7; i++) begin
            cfg_valid = 1'b1; cfg_data = vec[i].rec; sb_q.push_back(vec[i].exp);
            tick();
        end
        cfg_valid = 1'b0;
        check("drain_done", done, 1);
        tick();
        check("drain_sb", sb_q.size(), 0);

        // Illegal record inside a 2-word load
        run_load(0, 3, 2, 1'b1);

        // Remaining table entries on RCA 3
        run_load(3, 7, 2, 1'b0);

        // Abort after 1 of 4 records
        start = 1'b1; start_rca = 2'd3; start_num_words = 9'd4;
        tick();
        start = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_data = vec[7].rec; sb_q.push_back(vec[7].exp);
        tick();
        cfg_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_start_ready", start_ready, 1);
        check("abort_flag", aborted, 1);
        check("abort_lock", rca_lock, 0);
        check("abort_cfg_ready", cfg_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done, 0);
            tick();
        end
        check("abort_sb", sb_q.size(), 0);

        // Zero-word load plus an ignored second start while busy
        start = 1'b1; start_rca = 2'd0; start_num_words = 9'd0;
        tick();
        start_rca = 2'd2; start_num_words = 9'd5;
        check("zero_lock", rca_lock, 4'b0001);
        check("zero_aborted_clr", aborted, 0);
        tick();
        check("zero_done", done, 1);
        start = 1'b0;
        tick();
        check("zero_done_low", done, 0);
        check("zero_idle", start_ready, 1);
        check("zero_lock_low", rca_lock, 0);
        check("zero_sel_kept", rca_sel, 0);

        // Reset mid-load
        start = 1'b1; start_rca = 2'd1; start_num_words = 9'd3;
        tick();
        start = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_data = vec[8].rec; sb_q.push_back(vec[8].exp);
        tick();
        cfg_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_outputs", act, 0);
        check("mrst_lock", rca_lock, 0);
        check("mrst_cfg_ready", cfg_ready, 0);
        check("mrst_done", done, 0);
        check("mrst_aborted", aborted, 0);
        check("mrst_idle", start_ready, 1);
        check("mrst_sb", sb_q.size(), 0);
        tick();
        run_load(1, 0, 3, 1'b0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
